// File: rtl/pc_unit.sv
// Purpose : fetch-stage program counter with on-chip next-PC selection and a circular return-address stack.
// Latency : 1 cycle; a request sampled at a rising edge is visible on pc (and the RAS outputs) after that edge.
// Backpressure: ena=0 stalls the unit; all state holds and every request is ignored.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset (overrides ena)
//   ena             advance enable
//   jump/call       absolute redirect to jump_target (call also pushes pc+STEP)
//   branch          relative redirect by branch_offset
//   ret             pop the RAS top into pc
//   exc             redirect to EXC_VECTOR and flush the RAS
//   pc              current program counter
//   ras_count       valid RAS entries, 0..RAS_DEPTH
//   ras_overflow    sticky: a call happened while the RAS was full
//   ras_underflow   sticky: a ret happened while the RAS was empty
module pc_unit #(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0040_0004,
    parameter int          STEP         = 4,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic                         jump,
    input  logic [WIDTH-1:0]             jump_target,
    input  logic                         branch,
    input  logic [WIDTH-1:0]             branch_offset,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         exc,
    output logic [WIDTH-1:0]             pc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [WIDTH-1:0] RST_PC   = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_VECTOR);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [CW-1:0]    CNT_FULL = CW'(RAS_DEPTH);

    // Return-address storage; never reset, only ras_count says what is valid.
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_ptr;

    logic [WIDTH-1:0] pc_seq;
    logic [PW-1:0]    top_idx;
    logic             ras_full;

    logic [WIDTH-1:0] pc_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic [PW-1:0]    ptr_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;
    logic             push;

    assign pc_seq   = pc + STEP_W;
    // Pointer addresses the next free slot, so the top lives one below it (mod depth).
    assign top_idx  = ras_ptr - PW'(1);
    assign ras_full = (ras_count == CNT_FULL);

    always_comb begin
        pc_nxt  = pc;
        cnt_nxt = ras_count;
        ptr_nxt = ras_ptr;
        ovf_nxt = ras_overflow;
        unf_nxt = ras_underflow;
        push    = 1'b0;
        if (ena) begin
            if (exc) begin
                pc_nxt  = EXC_PC;
                cnt_nxt = '0;
                ptr_nxt = '0;
            end else if (ret) begin
                if (ras_count != '0) begin
                    pc_nxt  = ras_mem[top_idx];
                    cnt_nxt = ras_count - CW'(1);
                    ptr_nxt = top_idx;
                end else begin
                    // Empty stack: fall through sequentially and remember the underflow.
                    pc_nxt  = pc_seq;
                    unf_nxt = 1'b1;
                end
            end else if (call) begin
                push    = 1'b1;
                ptr_nxt = ras_ptr + PW'(1);
                pc_nxt  = jump_target;
                // When full the push wraps onto the oldest entry; count saturates.
                if (ras_full) begin
                    ovf_nxt = 1'b1;
                end else begin
                    cnt_nxt = ras_count + CW'(1);
                end
            end else if (jump) begin
                pc_nxt = jump_target;
            end else if (branch) begin
                pc_nxt = pc + branch_offset;
            end else begin
                pc_nxt = pc_seq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RST_PC;
            ras_count     <= '0;
            ras_ptr       <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc            <= pc_nxt;
            ras_count     <= cnt_nxt;
            ras_ptr       <= ptr_nxt;
            ras_overflow  <= ovf_nxt;
            ras_underflow <= unf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            ras_mem[ras_ptr] <= pc_seq;
        end
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit: the successor to the plain enable-gated PC register. Holds the current PC and computes the next PC on-chip from sequential, branch, jump, call, return and exception requests. Includes a small circular return-address stack (RAS) with sticky overflow/underflow flags. Sits in the fetch stage and drives the instruction-memory address.

Parameters:
WIDTH, 32, PC and address width in bits (>= 8)
RESET_VECTOR, 32'h0040_0000, PC value loaded by reset (truncated to WIDTH)
EXC_VECTOR, 32'h0040_0004, PC value loaded on exception (truncated to WIDTH)
STEP, 4, sequential increment and call return-offset
RAS_DEPTH, 4, return-address stack entries (power of two, >= 2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
ena  in  1  advance enable; 0 = stall, all state held, all requests ignored
jump  in  1  absolute jump request
jump_target  in  WIDTH  target for jump and call
branch  in  1  taken-branch request
branch_offset  in  WIDTH  two's-complement offset added to current pc
call  in  1  call request: push return address, go to jump_target
ret  in  1  return request: pop RAS top into pc
exc  in  1  exception request
pc  out  WIDTH  current program counter (registered)
ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries, 0..RAS_DEPTH
ras_overflow  out  1  sticky: a call occurred with RAS full
ras_underflow  out  1  sticky: a ret occurred with RAS empty

Behaviour:
- Reset (rst=1 at rising edge, overrides ena): pc=RESET_VECTOR, ras_count=0, RAS pointer=0, both flags=0. RAS storage contents need not be cleared.
- All outputs are registered; a request sampled at edge N takes effect in pc after edge N (1-cycle latency).
- ena=0: pc, RAS, ras_count and flags all hold.
- ena=1, fixed priority, exactly one action per cycle:
  1. exc: pc=EXC_VECTOR; ras_count=0, pointer=0 (RAS flushed); flags held.
  2. ret: if ras_count>0, pc=RAS[top], ras_count-1, pointer-1 mod RAS_DEPTH. If ras_count=0, pc=pc+STEP and ras_underflow=1.
  3. call: RAS[pointer]=pc+STEP, pointer+1 mod RAS_DEPTH, pc=jump_target. If ras_count<RAS_DEPTH, ras_count+1. If full, the oldest entry is overwritten, ras_count stays RAS_DEPTH, and ras_overflow=1.
  4. jump: pc=jump_target.
  5. branch: pc=pc+branch_offset.
  6. none: pc=pc+STEP.
- Lower-priority requests asserted with a higher one are dropped entirely (e.g. call+ret = ret only, with no push).
- All arithmetic is modulo 2^WIDTH; wrap-around is silent (pc=all-ones-3 with STEP=4 goes to 0). No alignment checking; targets are used as given.
- RAS top = RAS[(pointer-1) mod RAS_DEPTH].
- Flags clear only on reset.
- Reset mid-sequence discards all pending RAS contents; the first post-reset ret underflows.

Test Plan:
- Reset then 3 idle cycles with ena=1 -> pc 0x00400000, 0x00400004, 0x00400008, 0x0040000C; ras_count=0; flags 0.
- pc=0x00400010, branch=1, branch_offset=0xFFFFFFF8 -> pc=0x00400008. Then jump=1, jump_target=0x00400100 -> pc=0x00400100. Then ena=0 for 3 cycles with jump asserted -> pc holds 0x00400100.
- call from pc=0x00400020 to 0x00401000 -> pc=0x00401000, ras_count=1. Then ret -> pc=0x00400024, ras_count=0. Then ret again -> pc=0x00400028, ras_underflow=1 and it stays 1.
- 5 nested calls with RAS_DEPTH=4 -> ras_count=4, ras_overflow=1. Then 4 rets return the 4 most recent return addresses in LIFO order. A 5th ret underflows.
- exc+ret+call in the same cycle with ras_count=2 -> pc=0x00400004, ras_count=0, no push. Also: pc=0xFFFFFFFC idle -> pc=0x00000000.
- rst asserted mid-call-chain (ras_count=3) with ena=0 -> next edge pc=0x00400000, ras_count=0, flags 0.
